// File: rtl/spi_rx_fifo_peripheral.sv
// SPI receive peripheral: synchronises the SPI pins, assembles FRAME_BITS-bit words
// in any SPI mode and queues them in a first-word-fall-through FIFO with valid/ready.
module spi_rx_fifo_peripheral #(
   parameter int FRAME_BITS = 8,
   parameter int FIFO_DEPTH = 4,
   parameter int CPOL       = 0,
   parameter int CPHA       = 0,
   parameter int MSB_FIRST  = 1
) (
   input  logic                               clk,
   input  logic                               rst,
   input  logic                               SCLK,
   input  logic                               COPI,
   input  logic                               spi_cs_n,
   input  logic                               rx_enable,
   output logic [FRAME_BITS-1:0]              rx_data,
   output logic                               rx_valid,
   input  logic                               rx_ready,
   output logic                               rx_data_is_zero,
   output logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_level,
   output logic                               overrun,
   output logic                               frame_abort,
   input  logic                               clear_flags
);

   localparam int LW = $clog2(FIFO_DEPTH + 1);
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = $clog2(FRAME_BITS);
   localparam logic SAMPLE_RISE = (CPOL == CPHA);
   // Bit order {cs, copi, sclk}; CS resets low so a reset mid-transfer cannot fake a cs_fall.
   localparam logic [2:0] SYNC_INIT = {2'b00, 1'(CPOL)};

   typedef enum logic [1:0] {IDLE, SHIFT, SKIP} state_t;

   logic [2:0]            s1_reg, s2_reg, s3_reg;
   logic                  sample_edge, cs_fall, cs_high, copi_bit;
   state_t                state_reg, state_next;
   logic                  start_frame, shift_en, abort_comb, last_bit;
   logic [CW-1:0]         bit_cnt_reg;
   logic [FRAME_BITS-1:0] shift_reg, shift_in;
   logic                  push_reg;
   logic [FRAME_BITS-1:0] push_word_reg;

   logic [FRAME_BITS-1:0] mem [FIFO_DEPTH];
   logic [PW-1:0]         wr_ptr_reg, rd_ptr_reg, rd_ptr_next;
   logic [LW-1:0]         level_reg, level_next;
   logic                  pop, full, push_ok, drop;
   logic [FRAME_BITS-1:0] head_next;
   logic [FRAME_BITS-1:0] rx_data_reg;
   logic                  rx_valid_reg, rx_zero_reg, overrun_reg;

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_reg <= SYNC_INIT;
         s2_reg <= SYNC_INIT;
         s3_reg <= SYNC_INIT;
      end else begin
         s1_reg <= {spi_cs_n, COPI, SCLK};
         s2_reg <= s1_reg;
         s3_reg <= s2_reg;
      end
   end

   assign sample_edge = SAMPLE_RISE ? (s2_reg[0] & ~s3_reg[0]) : (~s2_reg[0] & s3_reg[0]);
   assign cs_fall     = s3_reg[2] & ~s2_reg[2];
   assign cs_high     = s2_reg[2];
   assign copi_bit    = s3_reg[1];

   always_ff @(posedge clk) begin
      if (rst) state_reg <= SKIP;
      else     state_reg <= state_next;
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:    if (cs_fall) state_next = rx_enable ? SHIFT : SKIP;
         SHIFT:   if (cs_high) state_next = IDLE;
         SKIP:    if (cs_high) state_next = IDLE;
         default: state_next = SKIP;
      endcase
   end

   always_comb begin
      start_frame = 1'b0;
      shift_en    = 1'b0;
      abort_comb  = 1'b0;
      case (state_reg)
         IDLE:  start_frame = cs_fall & rx_enable;
         SHIFT: begin
            if (cs_high) abort_comb = (bit_cnt_reg != '0);
            else         shift_en   = sample_edge;
         end
         default: ;
      endcase
   end

   assign frame_abort = abort_comb & ~rst;
   assign last_bit    = (bit_cnt_reg == CW'(FRAME_BITS - 1));
   assign shift_in    = (MSB_FIRST != 0) ? {shift_reg[FRAME_BITS-2:0], copi_bit}
                                         : {copi_bit, shift_reg[FRAME_BITS-1:1]};

   always_ff @(posedge clk) begin
      if (rst) begin
         bit_cnt_reg   <= '0;
         shift_reg     <= '0;
         push_reg      <= 1'b0;
         push_word_reg <= '0;
      end else begin
         push_reg <= shift_en & last_bit;
         if (shift_en && last_bit) push_word_reg <= shift_in;
         if (start_frame) begin
            bit_cnt_reg <= '0;
            shift_reg   <= '0;
         end else if (shift_en) begin
            shift_reg   <= shift_in;
            bit_cnt_reg <= last_bit ? '0 : bit_cnt_reg + CW'(1);
         end
      end
   end

   assign pop         = rx_valid_reg & rx_ready;
   assign full        = (level_reg == LW'(FIFO_DEPTH));
   assign push_ok     = push_reg & (~full | pop);
   assign drop        = push_reg & full & ~pop;
   assign rd_ptr_next = pop ? rd_ptr_reg + PW'(1) : rd_ptr_reg;

   always_comb begin
      level_next = level_reg;
      if (push_ok && !pop)      level_next = level_reg + LW'(1);
      else if (!push_ok && pop) level_next = level_reg - LW'(1);
   end

   // A word landing in the slot that becomes the head must bypass the array.
   assign head_next = (push_ok && (wr_ptr_reg == rd_ptr_next)) ? push_word_reg : mem[rd_ptr_next];

   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr_reg] <= push_word_reg;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_reg   <= '0;
         rd_ptr_reg   <= '0;
         level_reg    <= '0;
         rx_data_reg  <= '0;
         rx_valid_reg <= 1'b0;
         rx_zero_reg  <= 1'b0;
         overrun_reg  <= 1'b0;
      end else begin
         if (push_ok) wr_ptr_reg <= wr_ptr_reg + PW'(1);
         rd_ptr_reg   <= rd_ptr_next;
         level_reg    <= level_next;
         rx_data_reg  <= head_next;
         rx_valid_reg <= (level_next != '0);
         rx_zero_reg  <= (level_next != '0) && (head_next == '0);
         if (drop)             overrun_reg <= 1'b1;
         else if (clear_flags) overrun_reg <= 1'b0;
      end
   end

   assign rx_data         = rx_data_reg;
   assign rx_valid        = rx_valid_reg;
   assign rx_data_is_zero = rx_zero_reg;
   assign fifo_level      = level_reg;
   assign overrun         = overrun_reg;

endmodule

// File: tb/tb_spi_rx_fifo_peripheral.sv
// Directed bench: a default mode-0 instance plus four 12-bit LSB-first instances,
// one per SPI mode, driven from a shared base SCLK waveform.
module tb_spi_rx_fifo_peripheral;

   logic clk, rst;
   int   n_checks, n_fail;

   // Default instance
   logic       sclk_a, copi_a, cs_a, en_a, ready_a, clr_a;
   logic [7:0] data_a;
   logic [2:0] level_a;
   logic       valid_a, zero_a, ovr_a, abort_a;

   // Mode instances
   logic        base_sclk, copi_c0, copi_c1, cs_m, ready_m;
   logic [11:0] data_m [4];
   logic [2:0]  level_m [4];
   logic        valid_m [4];
   logic        zero_m [4];
   logic        ovr_m [4];
   logic        abort_m [4];

   int abort_cnt_a, abort_cnt_m;

   spi_rx_fifo_peripheral dut_a (
      .clk(clk), .rst(rst), .SCLK(sclk_a), .COPI(copi_a), .spi_cs_n(cs_a),
      .rx_enable(en_a), .rx_data(data_a), .rx_valid(valid_a), .rx_ready(ready_a),
      .rx_data_is_zero(zero_a), .fifo_level(level_a), .overrun(ovr_a),
      .frame_abort(abort_a), .clear_flags(clr_a)
   );

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_mode
         logic sclk_w, copi_w;
         assign sclk_w = base_sclk ^ 1'(gi / 2);
         assign copi_w = ((gi % 2) != 0) ? copi_c1 : copi_c0;
         spi_rx_fifo_peripheral #(
            .FRAME_BITS(12), .FIFO_DEPTH(4), .CPOL(gi / 2), .CPHA(gi % 2), .MSB_FIRST(0)
         ) dut_m (
            .clk(clk), .rst(rst), .SCLK(sclk_w), .COPI(copi_w), .spi_cs_n(cs_m),
            .rx_enable(1'b1), .rx_data(data_m[gi]), .rx_valid(valid_m[gi]), .rx_ready(ready_m),
            .rx_data_is_zero(zero_m[gi]), .fifo_level(level_m[gi]), .overrun(ovr_m[gi]),
            .frame_abort(abort_m[gi]), .clear_flags(1'b0)
         );
      end
   endgenerate

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (abort_a === 1'b1) abort_cnt_a++;
      for (int i = 0; i < 4; i++) if (abort_m[i] === 1'b1) abort_cnt_m++;
   end

   initial begin
      #500000;
      $display("FAIL timeout: simulation did not reach the end");
      $fatal(1, "timeout");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end else begin
         $display("ok   %s: %0h", name, act);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Mode-0 MSB-first bits; optionally a one-cycle pop timed onto the push cycle of the last bit.
   task automatic send_a(input logic [7:0] val, input int nbits, input bit pop_last,
                         output logic v5, output logic [7:0] head);
      v5   = 1'b0;
      head = '0;
      for (int b = 0; b < nbits; b++) begin
         copi_a = val[7-b];
         tick(5);
         sclk_a = 1'b1;
         for (int c = 0; c < 5; c++) begin
            tick(1);
            if (b == nbits - 1) begin
               if (pop_last && c == 2) begin
                  ready_a = 1'b1;
                  head    = data_a;
               end
               if (pop_last && c == 3) ready_a = 1'b0;
               if (c == 4) v5 = valid_a;
            end
         end
         sclk_a = 1'b0;
      end
   endtask

   task automatic send_m(input logic [11:0] val);
      for (int b = 0; b < 12; b++) begin
         copi_c0 = val[b];
         tick(5);
         base_sclk = 1'b1;
         copi_c1   = val[b];
         tick(5);
         base_sclk = 1'b0;
      end
   endtask

   task automatic cs_low_a();
      cs_a = 1'b0;
      tick(5);
   endtask

   task automatic cs_high_a();
      tick(5);
      cs_a = 1'b1;
      tick(5);
   endtask

   task automatic pop_a();
      ready_a = 1'b1;
      tick(1);
      ready_a = 1'b0;
   endtask

   typedef struct {
      logic [7:0] tx;
      logic [7:0] exp_data;
      logic       exp_zero;
   } vec_t;

   initial begin
      vec_t       vecs [5];
      logic       v5;
      logic [7:0] hd;
      int         ab0;

      vecs[0] = '{8'hA5, 8'hA5, 1'b0};
      vecs[1] = '{8'h00, 8'h00, 1'b1};
      vecs[2] = '{8'hFF, 8'hFF, 1'b0};
      vecs[3] = '{8'h3C, 8'h3C, 1'b0};
      vecs[4] = '{8'h81, 8'h81, 1'b0};

      n_checks = 0; n_fail = 0; abort_cnt_a = 0; abort_cnt_m = 0;
      clk = 0; rst = 1;
      sclk_a = 0; copi_a = 0; cs_a = 1; en_a = 1; ready_a = 0; clr_a = 0;
      base_sclk = 0; copi_c0 = 0; copi_c1 = 0; cs_m = 1; ready_m = 0;

      tick(3);
      rst = 0;
      check("reset_valid", valid_a, 0);
      check("reset_data", data_a, 0);
      check("reset_zero", zero_a, 0);
      check("reset_level", level_a, 0);
      check("reset_overrun", ovr_a, 0);
      check("reset_abort", abort_a, 0);
      tick(5);

      // Single frames, mode 0
      for (int k = 0; k < 5; k++) begin
         cs_low_a();
         send_a(vecs[k].tx, 8, 1'b0, v5, hd);
         check($sformatf("vec%0d_valid_within5", k), v5, 1);
         cs_high_a();
         check($sformatf("vec%0d_data", k), data_a, vecs[k].exp_data);
         check($sformatf("vec%0d_zero", k), zero_a, vecs[k].exp_zero);
         check($sformatf("vec%0d_level", k), level_a, 1);
         pop_a();
         check($sformatf("vec%0d_empty_after_pop", k), valid_a, 0);
      end

      // All four modes, two frames streamed in one CS assertion
      cs_m = 1'b0;
      tick(5);
      send_m(12'h123);
      send_m(12'h000);
      tick(5);
      cs_m = 1'b1;
      tick(5);
      for (int i = 0; i < 4; i++) begin
         check($sformatf("mode%0d_level", i), level_m[i], 2);
         check($sformatf("mode%0d_data0", i), data_m[i], 12'h123);
         check($sformatf("mode%0d_zero0", i), zero_m[i], 0);
      end
      ready_m = 1'b1; tick(1); ready_m = 1'b0;
      for (int i = 0; i < 4; i++) begin
         check($sformatf("mode%0d_valid1", i), valid_m[i], 1);
         check($sformatf("mode%0d_data1", i), data_m[i], 12'h000);
         check($sformatf("mode%0d_zero1", i), zero_m[i], 1);
      end
      ready_m = 1'b1; tick(1); ready_m = 1'b0;
      for (int i = 0; i < 4; i++) check($sformatf("mode%0d_empty", i), valid_m[i], 0);
      check("modes_no_abort", abort_cnt_m, 0);

      // Overrun: five bytes into a four-word FIFO
      cs_low_a();
      for (int k = 1; k <= 5; k++) send_a(8'(k), 8, 1'b0, v5, hd);
      cs_high_a();
      check("ovr_level", level_a, 4);
      check("ovr_flag", ovr_a, 1);
      for (int k = 1; k <= 4; k++) begin
         check($sformatf("ovr_pop%0d", k), data_a, k);
         pop_a();
      end
      check("ovr_drained", valid_a, 0);
      check("ovr_still_set", ovr_a, 1);
      clr_a = 1'b1; tick(1); clr_a = 1'b0;
      check("ovr_cleared", ovr_a, 0);

      // Full FIFO with a pop in the push cycle
      cs_low_a();
      for (int k = 0; k < 4; k++) send_a(8'h11 + 8'(k), 8, 1'b0, v5, hd);
      send_a(8'h15, 8, 1'b1, v5, hd);
      cs_high_a();
      check("fullpop_head", hd, 8'h11);
      check("fullpop_no_overrun", ovr_a, 0);
      check("fullpop_level", level_a, 4);
      for (int k = 0; k < 4; k++) begin
         check($sformatf("fullpop_order%0d", k), data_a, 8'h12 + 8'(k));
         pop_a();
      end
      check("fullpop_drained", level_a, 0);

      // Abort after five bits
      ab0 = abort_cnt_a;
      cs_low_a();
      send_a(8'hB0, 5, 1'b0, v5, hd);
      cs_high_a();
      check("abort_pulses", abort_cnt_a - ab0, 1);
      check("abort_fifo_level", level_a, 0);
      cs_low_a();
      send_a(8'h5A, 8, 1'b0, v5, hd);
      cs_high_a();
      check("after_abort_data", data_a, 8'h5A);
      check("after_abort_level", level_a, 1);
      pop_a();

      // rx_enable low at cs_fall, raised mid-frame
      en_a = 1'b0;
      cs_low_a();
      send_a(8'hF0, 4, 1'b0, v5, hd);
      en_a = 1'b1;
      send_a(8'h0F, 4, 1'b0, v5, hd);
      send_a(8'h77, 8, 1'b0, v5, hd);
      cs_high_a();
      check("gated_level", level_a, 0);
      check("gated_valid", valid_a, 0);
      cs_low_a();
      send_a(8'hC3, 8, 1'b0, v5, hd);
      cs_high_a();
      check("gated_next_data", data_a, 8'hC3);
      check("gated_next_level", level_a, 1);
      pop_a();

      // Reset pulsed mid-frame with CS held low
      ab0 = abort_cnt_a;
      cs_low_a();
      send_a(8'h3E, 8, 1'b0, v5, hd);
      send_a(8'hE0, 3, 1'b0, v5, hd);
      check("prerst_level", level_a, 1);
      rst = 1'b1; tick(1); rst = 1'b0;
      check("midrst_level", level_a, 0);
      check("midrst_valid", valid_a, 0);
      send_a(8'hF8, 5, 1'b0, v5, hd);
      send_a(8'h42, 8, 1'b0, v5, hd);
      cs_high_a();
      check("midrst_nothing_captured", level_a, 0);
      check("midrst_no_abort", abort_cnt_a - ab0, 0);
      cs_low_a();
      send_a(8'h96, 8, 1'b0, v5, hd);
      cs_high_a();
      check("midrst_next_data", data_a, 8'h96);
      check("midrst_next_level", level_a, 1);
      check("midrst_next_zero", zero_a, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/spi_rx_fifo_peripheral.md
# spi_rx_fifo_peripheral

Parametrised SPI receive peripheral: samples SCLK/COPI/spi_cs_n from an external SPI controller, assembles FRAME_BITS-bit words in any of the four SPI modes, and buffers them in a FIFO_DEPTH-word first-word-fall-through FIFO with a valid/ready output handshake. It sits between the FPGA SPI pins and the image/command loader. Unlike the single-byte receiver, it accepts back-to-back frames within one chip-select assertion, flags overrun and aborted frames, and never joins a transfer mid-frame.

## Interface
- FRAME_BITS, 8: bits per word, 2..32.
- FIFO_DEPTH, 4: FIFO words; power of two, at least 2.
- CPOL, 0: idle SCLK level.
- CPHA, 0: 0 samples on the first SCLK edge, 1 on the second.
- MSB_FIRST, 1: 1 shifts left (first bit becomes the MSB); 0 shifts right (first bit becomes the LSB).

Ports:
- clk  in  1  system clock; the only clock.
- rst  in  1  synchronous, active-high reset.
- SCLK  in  1  SPI clock, asynchronous.
- COPI  in  1  SPI data, asynchronous.
- spi_cs_n  in  1  SPI chip select, active low, asynchronous.
- rx_enable  in  1  permits new frames to start.
- rx_data  out  FRAME_BITS  FIFO head word.
- rx_valid  out  1  FIFO not empty.
- rx_ready  in  1  consumer accepts the head word.
- rx_data_is_zero  out  1  rx_valid && rx_data == 0.
- fifo_level  out  $clog2(FIFO_DEPTH+1)  words held.
- overrun  out  1  sticky: a word was dropped because the FIFO was full.
- frame_abort  out  1  one-cycle pulse: CS deasserted with a partial word.
- clear_flags  in  1  clears overrun.

## Operation
- **Synchronisers.** SCLK, COPI and spi_cs_n each pass through two flops, then one delay flop.
  - Edge detection compares stage 2 with stage 3.
  - The COPI bit used is stage 3.
- **Sample edge.** Rising SCLK edge when CPOL == CPHA, falling edge otherwise.
- **cs_fall** is defined as: stage-3 CS high and stage-2 CS low.
- **States.** IDLE, SHIFT, SKIP.
  - **IDLE:**
    - cs_fall && rx_enable → SHIFT, clearing bit_cnt and shift_reg.
    - cs_fall && !rx_enable → SKIP.
  - **SHIFT:**
    - On a sample edge, shift in COPI and increment bit_cnt.
    - On the sample edge where bit_cnt == FRAME_BITS-1: push the completed word and set bit_cnt = 0. The state stays SHIFT, so the next frame follows in the same CS assertion.
    - CS high (stage 2) → IDLE. If bit_cnt != 0, pulse frame_abort and discard the partial word.
    - rx_enable is ignored during SHIFT.
  - **SKIP:** ignore SCLK. CS high (stage 2) → IDLE.
- **FIFO push:**
  - Accepted if the FIFO is not full, or if it is full and a pop occurs in the same cycle.
  - Otherwise the word is dropped and overrun is set.
- **FIFO pop** happens when rx_valid && rx_ready.
- **Same-cycle push and pop:**
  - Level is unchanged.
  - When empty, a push never pops, because rx_valid is still 0.
- Read and write pointers wrap modulo FIFO_DEPTH. fifo_level is tracked separately to distinguish full from empty.
- **overrun:**
  - Set by a dropped push; stays set until clear_flags or rst.
  - If clear_flags coincides with a drop, overrun stays set.

## Timing
- **Reset values.**
  - All outputs are 0: rx_valid, rx_data, rx_data_is_zero, fifo_level, overrun, frame_abort.
  - FIFO pointers are 0.
  - Reset state is SKIP.
  - SCLK sync flops reset to CPOL. COPI sync flops reset to 0.
  - CS sync flops reset to 0, i.e. treated as asserted. A reset asserted mid-transfer therefore waits in SKIP for a real CS deassert and never joins a frame mid-stream.
- **Latency.**
  - An SCLK/COPI pin edge is acted on 3 clk cycles later.
  - The word is written to the FIFO on the cycle after the final sample edge is detected.
  - rx_valid and rx_data update on the following edge.
- **Output registering.** rx_data is the registered FIFO head, not combinational from shift_reg.
- **Clock ratio.** clk must be at least 8× SCLK. SCLK high and low times must each be at least 3 clk cycles.
- **frame_abort** is asserted for exactly one cycle: the cycle the SHIFT→IDLE transition is taken.

## Test plan
- **Mode 0, one frame.** Defaults; send 0xA5 → rx_valid=1 with rx_data=0xA5 within 5 clk of the last rising SCLK; fifo_level=1; rx_data_is_zero=0.
- **All modes, streamed frames.** For each (CPOL,CPHA); MSB_FIRST=0, FRAME_BITS=12; stream 0x123 then 0x000 in one CS assertion →
  - pops return 0x123, then 0x000 with rx_data_is_zero=1;
  - frame_abort is never asserted.
- **Overrun.** FIFO_DEPTH=4, rx_ready=0; send 5 bytes 0x01..0x05 →
  - fifo_level=4 and overrun=1;
  - pops return 0x01..0x04;
  - clear_flags → overrun=0.
- **Full FIFO with simultaneous pop.** FIFO full, rx_ready=1 in the push cycle → no overrun; level stays 4; order preserved.
- **Abort.** Deassert CS after 5 bits → one frame_abort pulse; FIFO unchanged; the next full frame is received correctly.
- **Gated or mid-frame starts.**
  - rx_enable=0 at cs_fall, then raised mid-frame → nothing captured until the next CS cycle.
  - rst pulsed with CS low mid-frame → SKIP; no data until CS goes high then low again.
